fetch_sequencer: RTL and testbench

Sits after the PCAdder in the instruction fetch unit. It owns the PC register, drives PCResult into the PCAdder and takes back PCAddResult. It issues word fetches to a variable-latency instruction memory over a req/ready handshake and buffers returned instructions with their PC in a 2-entry queue for decode. It handles stall (backpressure) and branch redirect with flush of in-flight and queued instructions.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer_fetch_queue.sv | 77 +++++++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the reset PC default, word alignment mask, FSM encoding and queue entry layout.
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: PCAdder loop, instruction memory handshake, redirect and decode queue head.
// master = fetch_sequencer, slave = surrounding pipeline / memory.
interface fetch_sequencer_if;

    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        DecodeReady;

    modport master (
        output PCResult, IMemReq, IMemAddr, InstrValid, Instruction, InstrPC,
        input  PCAddResult, Redirect, RedirectPC, IMemReady, IMemRespValid,
               IMemRespData, DecodeReady
    );

    modport slave (
        input  PCResult, IMemReq, IMemAddr, InstrValid, Instruction, InstrPC,
        output PCAddResult, Redirect, RedirectPC, IMemReady, IMemRespValid,
               IMemRespData, DecodeReady
    );

endinterface

// File: rtl/fetch_sequencer_fetch_queue.sv
// Small FIFO of {pc, instr} pairs feeding decode; head is read combinationally.
// When empty the head output holds the last entry that left the queue.
module fetch_queue
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    fetch_entry_t  r_last;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_valid;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && w_valid && !i_flush;
    assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

    // NOTE: the storage array has no reset; entries are only visible behind r_count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
            if (w_valid) begin
                r_last <= r_mem[r_rd_ptr];
            end
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = w_valid;
    assign o_head  = w_valid ? r_mem[r_rd_ptr] : r_last;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding word fetch at a time,
// buffers responses for decode and squashes in-flight/queued work on redirect.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    fetch_sequencer_if.master  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_req_pc;
    logic [31:0]  w_req_pc_next;
    logic         r_discard;
    logic         w_discard_next;

    logic         w_req;
    logic         w_push;
    logic         w_pop;
    logic [CW-1:0] w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_head_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= word_align(RESET_PC);
            r_req_pc  <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_req_pc  <= w_req_pc_next;
            r_discard <= w_discard_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_req_pc_next  = r_req_pc;
        w_discard_next = r_discard;
        w_req          = 1'b0;
        w_push         = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_state_next = REQ;
            end
            REQ: begin
                // Nothing is outstanding in REQ, so a free queue slot is the only gate.
                w_req = (w_count < CW'(QDEPTH));
                if (w_req && bus.IMemReady) begin
                    w_req_pc_next  = r_pc;
                    w_pc_next      = word_align(bus.PCAddResult);
                    w_discard_next = bus.Redirect;
                    w_state_next   = WAIT;
                end
            end
            WAIT: begin
                if (bus.IMemRespValid) begin
                    w_push         = !r_discard && !bus.Redirect;
                    w_discard_next = 1'b0;
                    w_state_next   = REQ;
                end else if (bus.Redirect) begin
                    w_discard_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (bus.Redirect) begin
            w_pc_next = word_align(bus.RedirectPC);
        end
    end

    assign w_pop        = w_head_valid && bus.DecodeReady;
    assign w_push_entry = '{pc: r_req_pc, instr: bus.IMemRespData};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (bus.Redirect),
        .o_head      (w_head),
        .o_valid     (w_head_valid),
        .o_count     (w_count)
    );

    assign bus.PCResult    = r_pc;
    assign bus.IMemReq     = w_req;
    assign bus.IMemAddr    = word_align(r_pc);
    assign bus.InstrValid  = w_head_valid;
    assign bus.Instruction = w_head.instr;
    assign bus.InstrPC     = w_head.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a negedge-driven memory/decode model feeds the DUT,
// and each scenario task compares logged fetch addresses and decoded PCs against fixed lists.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // PCAdder model
    assign bus.PCAddResult = bus.PCResult + 32'd4;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment knobs, written by the tests just after a rising edge
    int          mem_latency  = 1;
    bit          mem_ready_en = 1'b1;
    bit          dec_ready_en = 1'b1;
    int          stall_left   = 0;
    logic [31:0] stall_addr   = '0;
    int          redir_mode   = 0;
    logic [31:0] redir_addr   = '0;
    logic [31:0] redir_target = '0;

    int          countdown = 0;
    logic [31:0] resp_addr = '0;

    logic [31:0] acc_q [$];
    logic [31:0] pop_pc_q [$];
    logic [31:0] pop_ins_q [$];
    logic [31:0] stall_addr_q [$];
    logic [31:0] stall_pc_q [$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Memory + decode model: acts on the falling edge only
    initial begin : driver
        bit accept;
        bit fire_wait;
        bit fire;
        bus.Redirect      = 1'b0;
        bus.RedirectPC    = '0;
        bus.IMemReady     = 1'b0;
        bus.IMemRespValid = 1'b0;
        bus.IMemRespData  = '0;
        bus.DecodeReady   = 1'b0;
        forever begin
            @(negedge Clk);
            bus.DecodeReady   = dec_ready_en;
            bus.Redirect      = 1'b0;
            bus.IMemRespValid = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    bus.IMemRespValid = 1'b1;
                    bus.IMemRespData  = instr_of(resp_addr);
                end
            end
            fire_wait = (countdown > 0) && (resp_addr == redir_addr);
            bus.IMemReady = mem_ready_en;
            if (bus.IMemReq && bus.IMemReady && stall_left > 0 && bus.IMemAddr == stall_addr) begin
                bus.IMemReady = 1'b0;
                stall_left--;
                stall_addr_q.push_back(bus.IMemAddr);
                stall_pc_q.push_back(bus.PCResult);
            end
            accept = bus.IMemReq && bus.IMemReady;
            if (accept) begin
                acc_q.push_back(bus.IMemAddr);
                resp_addr = bus.IMemAddr;
                countdown = mem_latency;
            end
            case (redir_mode)
                1:       fire = fire_wait;
                2:       fire = bus.IMemRespValid && (resp_addr == redir_addr);
                3:       fire = accept && (bus.IMemAddr == redir_addr);
                4:       fire = 1'b1;
                default: fire = 1'b0;
            endcase
            if (fire) begin
                bus.Redirect   = 1'b1;
                bus.RedirectPC = redir_target;
                redir_mode     = 0;
            end
            if (bus.InstrValid && bus.DecodeReady) begin
                pop_pc_q.push_back(bus.InstrPC);
                pop_ins_q.push_back(bus.Instruction);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 400 && acc_q.size() < n; i++) step(1);
    endtask

    task automatic wait_pop(input int n);
        for (int i = 0; i < 400 && pop_pc_q.size() < n; i++) step(1);
    endtask

    task automatic clear_logs;
        acc_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
        stall_addr_q.delete();
        stall_pc_q.delete();
    endtask

    task automatic do_reset(input int lat);
        step(1);
        Reset        = 1'b1;
        countdown    = 0;
        redir_mode   = 0;
        stall_left   = 0;
        mem_latency  = lat;
        mem_ready_en = 1'b1;
        dec_ready_en = 1'b1;
        clear_logs();
        step(2);
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        step(2);
        n_checks++; if (bus.PCResult !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.PCResult, 32'h0); end
        n_checks++; if (bus.IMemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.IMemReq); end
        n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.InstrValid); end
        n_checks++; if (bus.Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", bus.Instruction); end
        n_checks++; if (bus.InstrPC !== 32'h0) begin n_fail++; $display("FAIL reset_instrpc: got %h expected 0", bus.InstrPC); end
        Reset = 1'b0;
        step(1);
        n_checks++; if (bus.IMemReq !== 1'b1) begin n_fail++; $display("FAIL idle_to_req: got %b expected 1", bus.IMemReq); end
    endtask

    task automatic test_basic_fetch;
        logic [31:0] exp_acc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] exp_pop [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] got;
        do_reset(1);
        step(1);
        n_checks++; if (bus.IMemAddr !== 32'h0) begin n_fail++; $display("FAIL basic_first_addr: got %h expected 0", bus.IMemAddr); end
        step(1);
        n_checks++; if (bus.PCResult !== 32'h4) begin n_fail++; $display("FAIL basic_pc_ahead: got %h expected 4", bus.PCResult); end
        n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %b expected 0", bus.InstrValid); end
        step(1);
        n_checks++; if (bus.InstrValid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", bus.InstrValid); end
        n_checks++; if (bus.Instruction !== instr_of(32'h0)) begin n_fail++; $display("FAIL basic_head_instr: got %h expected %h", bus.Instruction, instr_of(32'h0)); end
        wait_acc(4);
        n_checks++; if (bus.PCResult !== 32'h10) begin n_fail++; $display("FAIL basic_pc_after4: got %h expected 10", bus.PCResult); end
        for (int i = 0; i < 4; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_acc[i]) begin n_fail++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, got, exp_acc[i]); end
        end
        n_checks++; if (pop_pc_q.size() !== 3) begin n_fail++; $display("FAIL basic_pop_count: got %0d expected 3", pop_pc_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_pop[i]) begin n_fail++; $display("FAIL basic_instrpc[%0d]: got %h expected %h", i, got, exp_pop[i]); end
            got = (i < pop_ins_q.size()) ? pop_ins_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== instr_of(exp_pop[i])) begin n_fail++; $display("FAIL basic_instr[%0d]: got %h expected %h", i, got, instr_of(exp_pop[i])); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pop [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] got;
        do_reset(1);
        dec_ready_en = 1'b0;
        step(10);
        n_checks++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL bp_fetch_count: got %0d expected 2", acc_q.size()); end
        n_checks++; if (bus.IMemReq !== 1'b0) begin n_fail++; $display("FAIL bp_req_gated: got %b expected 0", bus.IMemReq); end
        n_checks++; if (bus.InstrValid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", bus.InstrValid); end
        n_checks++; if (bus.InstrPC !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h expected 0", bus.InstrPC); end
        n_checks++; if (pop_pc_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d expected 0", pop_pc_q.size()); end
        dec_ready_en = 1'b1;
        wait_acc(3);
        got = (acc_q.size() > 2) ? acc_q[2] : 32'hxxxx_xxxx;
        n_checks++; if (got !== 32'h8) begin n_fail++; $display("FAIL bp_resume_addr: got %h expected 8", got); end
        wait_pop(3);
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_pop[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got, exp_pop[i]); end
            got = (i < pop_ins_q.size()) ? pop_ins_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== instr_of(exp_pop[i])) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, got, instr_of(exp_pop[i])); end
        end
    endtask

    task automatic test_mem_stall;
        logic [31:0] exp_acc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] got;
        do_reset(1);
        stall_addr = 32'h8;
        stall_left = 3;
        wait_acc(4);
        n_checks++; if (stall_addr_q.size() !== 3) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 3", stall_addr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < stall_addr_q.size()) ? stall_addr_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 8", i, got); end
            got = (i < stall_pc_q.size()) ? stall_pc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected 8", i, got); end
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_acc[i]) begin n_fail++; $display("FAIL stall_seq[%0d]: got %h expected %h", i, got, exp_acc[i]); end
        end
    endtask

    task automatic test_redirect_wait;
        logic [31:0] exp_acc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100};
        logic [31:0] exp_pop [4] = '{32'h0, 32'h4, 32'h8, 32'h100};
        logic [31:0] got;
        do_reset(5);
        redir_addr   = 32'hC;
        redir_target = 32'h0000_0103;
        redir_mode   = 1;
        wait_acc(5);
        wait_pop(4);
        for (int i = 0; i < 5; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_acc[i]) begin n_fail++; $display("FAIL rdw_addr[%0d]: got %h expected %h", i, got, exp_acc[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_pop[i]) begin n_fail++; $display("FAIL rdw_instrpc[%0d]: got %h expected %h", i, got, exp_pop[i]); end
            got = (i < pop_ins_q.size()) ? pop_ins_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== instr_of(exp_pop[i])) begin n_fail++; $display("FAIL rdw_instr[%0d]: got %h expected %h", i, got, instr_of(exp_pop[i])); end
        end
    endtask

    task automatic test_redirect_coincident(input int mode, input logic [31:0] target, input logic [31:0] aligned);
        logic [31:0] exp_acc [4];
        logic [31:0] exp_pop [3];
        logic [31:0] got;
        exp_acc = '{32'h0, 32'h4, 32'h8, aligned};
        exp_pop = '{32'h0, 32'h4, aligned};
        do_reset(1);
        redir_addr   = 32'h8;
        redir_target = target;
        redir_mode   = mode;
        wait_acc(4);
        wait_pop(3);
        for (int i = 0; i < 4; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_acc[i]) begin n_fail++; $display("FAIL rdc%0d_addr[%0d]: got %h expected %h", mode, i, got, exp_acc[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_pop[i]) begin n_fail++; $display("FAIL rdc%0d_instrpc[%0d]: got %h expected %h", mode, i, got, exp_pop[i]); end
            got = (i < pop_ins_q.size()) ? pop_ins_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== instr_of(exp_pop[i])) begin n_fail++; $display("FAIL rdc%0d_instr[%0d]: got %h expected %h", mode, i, got, instr_of(exp_pop[i])); end
        end
    endtask

    task automatic test_flush_queue;
        logic [31:0] exp_acc [4] = '{32'h0, 32'h4, 32'h40, 32'h44};
        logic [31:0] exp_pop [2] = '{32'h40, 32'h44};
        logic [31:0] got;
        do_reset(1);
        dec_ready_en = 1'b0;
        step(8);
        n_checks++; if (bus.InstrValid !== 1'b1) begin n_fail++; $display("FAIL flush_prefill: got %b expected 1", bus.InstrValid); end
        redir_target = 32'h0000_0040;
        redir_mode   = 4;
        step(1);
        n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.InstrValid); end
        n_checks++; if (bus.PCResult !== 32'h40) begin n_fail++; $display("FAIL flush_pc: got %h expected 40", bus.PCResult); end
        dec_ready_en = 1'b1;
        wait_pop(2);
        for (int i = 0; i < 2; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_pop[i]) begin n_fail++; $display("FAIL flush_instrpc[%0d]: got %h expected %h", i, got, exp_pop[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (got !== exp_acc[i]) begin n_fail++; $display("FAIL flush_addr[%0d]: got %h expected %h", i, got, exp_acc[i]); end
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] got;
        do_reset(5);
        wait_acc(3);
        n_checks++; if (bus.PCResult !== 32'hC) begin n_fail++; $display("FAIL rmw_pre_pc: got %h expected c", bus.PCResult); end
        n_checks++; if (bus.InstrPC !== 32'h4) begin n_fail++; $display("FAIL rmw_pre_hold: got %h expected 4", bus.InstrPC); end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++; if (bus.PCResult !== 32'h0) begin n_fail++; $display("FAIL rmw_async_pc: got %h expected 0", bus.PCResult); end
        n_checks++; if (bus.InstrPC !== 32'h0) begin n_fail++; $display("FAIL rmw_async_instrpc: got %h expected 0", bus.InstrPC); end
        n_checks++; if (bus.Instruction !== 32'h0) begin n_fail++; $display("FAIL rmw_async_instr: got %h expected 0", bus.Instruction); end
        n_checks++; if (bus.IMemReq !== 1'b0) begin n_fail++; $display("FAIL rmw_async_req: got %b expected 0", bus.IMemReq); end
        mem_ready_en = 1'b0;
        clear_logs();
        step(1);
        Reset = 1'b0;
        step(6);
        n_checks++; if (bus.InstrValid !== 1'b0) begin n_fail++; $display("FAIL rmw_late_resp: got %b expected 0", bus.InstrValid); end
        n_checks++; if (bus.IMemReq !== 1'b1) begin n_fail++; $display("FAIL rmw_req_after: got %b expected 1", bus.IMemReq); end
        mem_ready_en = 1'b1;
        wait_pop(1);
        got = (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx;
        n_checks++; if (got !== 32'h0) begin n_fail++; $display("FAIL rmw_first_addr: got %h expected 0", got); end
        got = (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'hxxxx_xxxx;
        n_checks++; if (got !== 32'h0) begin n_fail++; $display("FAIL rmw_first_pc: got %h expected 0", got); end
        got = (pop_ins_q.size() > 0) ? pop_ins_q[0] : 32'hxxxx_xxxx;
        n_checks++; if (got !== instr_of(32'h0)) begin n_fail++; $display("FAIL rmw_first_instr: got %h expected %h", got, instr_of(32'h0)); end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_mem_stall();
        test_redirect_wait();
        test_redirect_coincident(2, 32'h0000_0200, 32'h0000_0200);
        test_redirect_coincident(3, 32'h0000_0302, 32'h0000_0300);
        test_flush_queue();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
